// File: rtl/regfile_sb.sv
// Register file with two combinational read ports, one synchronous write port and a per-entry pending scoreboard.
// Latency: reads and busy flags are combinational (optional same-cycle write bypass); writes, pending bits and pend_cnt update at the clock edge.
// Backpressure: none; busy1/busy2 flag in-flight writes so the controller can stall on read-after-write hazards.
module regfile_sb #(
    parameter int WIDTH    = 32,
    parameter int AW       = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we3,
    input  logic [AW-1:0]    wa3,
    input  logic [WIDTH-1:0] wd3,
    input  logic [AW-1:0]    ra1,
    input  logic [AW-1:0]    ra2,
    output logic [WIDTH-1:0] rd1,
    output logic [WIDTH-1:0] rd2,
    input  logic             issue,
    input  logic [AW-1:0]    issue_a,
    output logic             busy1,
    output logic             busy2,
    output logic [AW:0]      pend_cnt
);

    localparam int NREGS = 1 << AW;

    logic [WIDTH-1:0] r_mem [NREGS];
    logic [NREGS-1:0] r_pend;
    logic [AW:0]      r_pend_cnt;

    logic             w_wr_en;
    logic             w_iss_en;
    logic [NREGS-1:0] w_pend_nxt;
    logic [AW:0]      w_pend_pop;

    // Gating with reset keeps the bypass paths quiet while reset is held.
    assign w_wr_en  = we3   && reset && !(ZERO_REG != 0 && wa3 == '0);
    assign w_iss_en = issue && reset && !(ZERO_REG != 0 && issue_a == '0);

    // Clear before set: a same-edge issue to the written entry leaves it pending.
    always_comb begin
        w_pend_nxt = r_pend;
        if (w_wr_en) begin
            w_pend_nxt[wa3] = 1'b0;
        end
        if (w_iss_en) begin
            w_pend_nxt[issue_a] = 1'b1;
        end
        w_pend_pop = '0;
        for (int i = 0; i < NREGS; i++) begin
            w_pend_pop = w_pend_pop + {{AW{1'b0}}, w_pend_nxt[i]};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREGS; i++) begin
                r_mem[i] <= '0;
            end
            r_pend     <= '0;
            r_pend_cnt <= '0;
        end else begin
            if (w_wr_en) begin
                r_mem[wa3] <= wd3;
            end
            r_pend     <= w_pend_nxt;
            r_pend_cnt <= w_pend_pop;
        end
    end

    function automatic logic [WIDTH-1:0] read_port(input logic [AW-1:0] ra);
        if (!reset || (ZERO_REG != 0 && ra == '0)) begin
            return '0;
        end
        if (BYPASS != 0 && w_wr_en && wa3 == ra) begin
            return wd3;
        end
        return r_mem[ra];
    endfunction

    // A bypassed write resolves the hazard unless a new issue re-claims the entry.
    function automatic logic busy_port(input logic [AW-1:0] ra);
        if (!reset) begin
            return 1'b0;
        end
        if (BYPASS != 0 && w_wr_en && wa3 == ra && !(w_iss_en && issue_a == ra)) begin
            return 1'b0;
        end
        return r_pend[ra];
    endfunction

    always_comb begin
        rd1   = read_port(ra1);
        rd2   = read_port(ra2);
        busy1 = busy_port(ra1);
        busy2 = busy_port(ra2);
    end

    assign pend_cnt = r_pend_cnt;

endmodule

// File: tb/tb_regfile_sb.sv
// Randomised and directed bench for regfile_sb with a queue-based scoreboard.
// Driver pushes expected outputs after each drive; a negedge monitor pops and compares.
module tb_regfile_sb;

    logic        clk;
    logic        reset;
    logic        we3;
    logic [4:0]  wa3;
    logic [31:0] wd3;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic        issue;
    logic [4:0]  issue_a;
    logic        busy1;
    logic        busy2;
    logic [5:0]  pend_cnt;

    // Second instance: narrow, no zero register, no bypass.
    logic        b_reset;
    logic        b_we3;
    logic [2:0]  b_wa3;
    logic [15:0] b_wd3;
    logic [2:0]  b_ra1;
    logic [2:0]  b_ra2;
    logic [15:0] b_rd1;
    logic [15:0] b_rd2;
    logic        b_issue;
    logic [2:0]  b_issue_a;
    logic        b_busy1;
    logic        b_busy2;
    logic [3:0]  b_pend_cnt;

    int checks   = 0;
    int failures = 0;
    int step_id  = 0;

    regfile_sb u_dut (
        .clk(clk), .reset(reset), .we3(we3), .wa3(wa3), .wd3(wd3),
        .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
        .issue(issue), .issue_a(issue_a),
        .busy1(busy1), .busy2(busy2), .pend_cnt(pend_cnt)
    );

    regfile_sb #(.WIDTH(16), .AW(3), .ZERO_REG(0), .BYPASS(0)) u_dut_b (
        .clk(clk), .reset(b_reset), .we3(b_we3), .wa3(b_wa3), .wd3(b_wd3),
        .ra1(b_ra1), .ra2(b_ra2), .rd1(b_rd1), .rd2(b_rd2),
        .issue(b_issue), .issue_a(b_issue_a),
        .busy1(b_busy1), .busy2(b_busy2), .pend_cnt(b_pend_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: plain arrays of architectural state.
    logic [31:0] m_mem [32];
    bit          m_pend [32];

    typedef struct {
        int          id;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic        b1;
        logic        b2;
        logic [5:0]  cnt;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;

    task automatic chk(input string nm, input int id, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s step=%0d got=%h exp=%h", nm, id, got, exp);
        end
    endtask

    function automatic void model_clear();
        for (int i = 0; i < 32; i++) begin
            m_mem[i]  = 32'h0;
            m_pend[i] = 1'b0;
        end
    endfunction

    // Applies the effect of the clock edge that just happened, using the inputs held across it.
    function automatic void model_edge();
        if (reset) begin
            if (we3 && wa3 != 5'd0) begin
                m_mem[wa3]  = wd3;
                m_pend[wa3] = 1'b0;
            end
            if (issue && issue_a != 5'd0) begin
                m_pend[issue_a] = 1'b1;
            end
        end
    endfunction

    function automatic logic [31:0] exp_read(input logic [4:0] ra);
        if (!reset || ra == 5'd0) return 32'h0;
        if (we3 && wa3 == ra) return wd3;
        return m_mem[ra];
    endfunction

    function automatic logic exp_busy(input logic [4:0] ra);
        if (!reset) return 1'b0;
        if (we3 && wa3 == ra && ra != 5'd0 && !(issue && issue_a == ra)) return 1'b0;
        return m_pend[ra];
    endfunction

    function automatic logic [5:0] exp_count();
        int n = 0;
        for (int i = 0; i < 32; i++) n += int'(m_pend[i]);
        return 6'(n);
    endfunction

    task automatic step(input logic rst, input logic we, input logic [4:0] wa, input logic [31:0] wd,
                        input logic [4:0] a1, input logic [4:0] a2, input logic iss, input logic [4:0] ia);
        exp_t e;
        @(posedge clk);
        #1;
        model_edge();
        reset   = rst;
        we3     = we;
        wa3     = wa;
        wd3     = wd;
        ra1     = a1;
        ra2     = a2;
        issue   = iss;
        issue_a = ia;
        if (!rst) model_clear();
        e.id  = step_id;
        e.rd1 = exp_read(a1);
        e.rd2 = exp_read(a2);
        e.b1  = exp_busy(a1);
        e.b2  = exp_busy(a2);
        e.cnt = exp_count();
        q.push_back(e);
        step_id++;
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            mon_e = q.pop_front();
            chk("rd1",      mon_e.id, rd1,              mon_e.rd1);
            chk("rd2",      mon_e.id, rd2,              mon_e.rd2);
            chk("busy1",    mon_e.id, {31'h0, busy1},   {31'h0, mon_e.b1});
            chk("busy2",    mon_e.id, {31'h0, busy2},   {31'h0, mon_e.b2});
            chk("pend_cnt", mon_e.id, {26'h0, pend_cnt}, {26'h0, mon_e.cnt});
        end
    end

    function automatic logic [4:0] rnd_addr();
        if ($urandom_range(0, 1) == 0) return 5'($urandom_range(0, 7));
        return 5'($urandom_range(0, 31));
    endfunction

    task automatic b_drive(input logic we, input logic [2:0] wa, input logic [15:0] wd,
                           input logic [2:0] a1, input logic iss, input logic [2:0] ia);
        @(posedge clk);
        #1;
        b_reset   = 1'b1;
        b_we3     = we;
        b_wa3     = wa;
        b_wd3     = wd;
        b_ra1     = a1;
        b_ra2     = a1;
        b_issue   = iss;
        b_issue_a = ia;
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; we3 = 1'b0; wa3 = '0; wd3 = '0; ra1 = '0; ra2 = '0; issue = 1'b0; issue_a = '0;
        b_reset = 1'b0; b_we3 = 1'b0; b_wa3 = '0; b_wd3 = '0; b_ra1 = '0; b_ra2 = '0;
        b_issue = 1'b0; b_issue_a = '0;
        model_clear();

        // Reset state, then a write that a mid-cycle reset must wipe.
        step(0, 0, 5'd0, 32'h0,        5'd5, 5'd3, 0, 5'd0);
        step(1, 1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd0, 0, 5'd0);
        step(1, 0, 5'd0, 32'h0,        5'd5, 5'd5, 0, 5'd0);
        step(0, 1, 5'd5, 32'h11111111, 5'd5, 5'd5, 1, 5'd5);
        step(1, 0, 5'd0, 32'h0,        5'd5, 5'd5, 0, 5'd0);

        // Write/read and the zero register.
        step(1, 1, 5'd3, 32'h12345678, 5'd1, 5'd2, 0, 5'd0);
        step(1, 1, 5'd0, 32'hFFFFFFFF, 5'd3, 5'd0, 0, 5'd0);
        step(1, 0, 5'd0, 32'h0,        5'd3, 5'd0, 0, 5'd0);

        // Same-cycle bypass.
        step(1, 1, 5'd7, 32'hA5A5A5A5, 5'd7, 5'd7, 0, 5'd0);
        step(1, 0, 5'd0, 32'h0,        5'd7, 5'd3, 0, 5'd0);

        // Scoreboard set/clear, and issue to r0.
        step(1, 0, 5'd0, 32'h0,  5'd4, 5'd9, 1, 5'd4);
        step(1, 0, 5'd0, 32'h0,  5'd4, 5'd9, 1, 5'd9);
        step(1, 1, 5'd4, 32'h44, 5'd4, 5'd9, 0, 5'd0);
        step(1, 0, 5'd0, 32'h0,  5'd4, 5'd9, 1, 5'd0);
        step(1, 0, 5'd0, 32'h0,  5'd4, 5'd0, 0, 5'd0);

        // Same-edge issue and write to one entry, then a repeated issue.
        step(1, 1, 5'd6, 32'h55, 5'd6, 5'd6, 1, 5'd6);
        step(1, 0, 5'd0, 32'h0,  5'd6, 5'd6, 1, 5'd6);
        step(1, 0, 5'd0, 32'h0,  5'd6, 5'd9, 0, 5'd0);

        // Fill every entry with issues, then drain with writes.
        for (int a = 0; a < 32; a++) step(1, 0, 5'd0, 32'h0, 5'(a), 5'd0, 1, 5'(a));
        step(1, 0, 5'd0, 32'h0, 5'd31, 5'd1, 0, 5'd0);
        for (int a = 0; a < 32; a++) step(1, 1, 5'(a), 32'(a * 3 + 1), 5'(a), 5'd2, 0, 5'd0);
        step(1, 0, 5'd0, 32'h0, 5'd31, 5'd1, 0, 5'd0);

        for (int n = 0; n < 600; n++) begin
            step(($urandom_range(0, 63) != 0), ($urandom_range(0, 2) != 0), rnd_addr(), $urandom,
                 rnd_addr(), rnd_addr(), ($urandom_range(0, 2) != 0), rnd_addr());
        end
        step(1, 0, 5'd0, 32'h0, 5'd1, 5'd2, 0, 5'd0);

        for (int n = 0; n < 10 && q.size() > 0; n++) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain got=%0d pending expectations exp=0", q.size());
        end

        // Narrow instance without bypass and without a zero register.
        b_drive(1, 3'd7, 16'hA5A5, 3'd7, 0, 3'd0);
        chk("b_nobypass_before", 0, {16'h0, b_rd1}, 32'h0);
        b_drive(0, 3'd0, 16'h0,    3'd7, 0, 3'd0);
        chk("b_after_edge",      1, {16'h0, b_rd1}, 32'hA5A5);
        b_drive(1, 3'd0, 16'h1234, 3'd0, 0, 3'd0);
        b_drive(0, 3'd0, 16'h0,    3'd0, 0, 3'd0);
        chk("b_r0_writable",     2, {16'h0, b_rd1}, 32'h1234);
        for (int a = 0; a < 8; a++) b_drive(0, 3'd0, 16'h0, 3'd0, 1, 3'(a));
        b_drive(0, 3'd0, 16'h0, 3'd0, 0, 3'd0);
        chk("b_fill_cnt",        3, {28'h0, b_pend_cnt}, 32'd8);
        chk("b_busy_r0",         4, {31'h0, b_busy1},    32'd1);
        b_drive(1, 3'd3, 16'h0033, 3'd3, 0, 3'd0);
        chk("b_busy_no_bypass",  5, {31'h0, b_busy2},    32'd1);
        for (int a = 0; a < 8; a++) b_drive(1, 3'(a), 16'(a + 16), 3'd0, 0, 3'd0);
        b_drive(0, 3'd0, 16'h0, 3'd5, 0, 3'd0);
        chk("b_drain_cnt",       6, {28'h0, b_pend_cnt}, 32'd0);
        chk("b_busy_cleared",    7, {31'h0, b_busy1},    32'd0);
        chk("b_r5_data",         8, {16'h0, b_rd1},      32'd21);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
